// File: rtl/vec_int_pkg.sv
// Shared types and helpers for the vectored interrupt controller.
package vec_int_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Width of a source index; a single source still needs one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Handler vector for a source, always computed at 32 bits.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [31:0] idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/vec_int_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder over the requestable sources.
module int_prio_enc #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  // Scan high to low so the lowest set bit is the last assignment.
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (req[i]) idx = IDX_W'(i);
  end

endmodule

// File: rtl/vec_int_ctrl.sv
// Vectored interrupt controller: edge capture, pending/mask, fixed
// priority, and a request/acknowledge/return handshake with the core.
module vec_int_ctrl
  import vec_int_pkg::*;
#(
  parameter int          NUM_SRC    = 4,
  parameter int          ADDR_W     = 32,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int          VEC_STRIDE = 8
) (
  input  logic                        Clk,
  input  logic                        reset,
  input  logic [NUM_SRC-1:0]          src,
  input  logic                        mask_we,
  input  logic [NUM_SRC-1:0]          mask_wd,
  input  logic                        int_ack,
  input  logic                        eret,
  output logic                        irq,
  output logic [ADDR_W-1:0]           int_addr,
  output logic                        in_service,
  output logic [idx_w(NUM_SRC)-1:0]   svc_id,
  output logic [NUM_SRC-1:0]          pending,
  output logic [NUM_SRC-1:0]          mask
);

  localparam int IDX_W = idx_w(NUM_SRC);

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] clr;
  logic               any;
  logic [IDX_W-1:0]   win_idx;
  logic               load;
  logic               ack_ok;
  logic [31:0]        win_addr;

  assign edge_det = src & ~src_q;
  assign win_addr = vec_addr(VEC_BASE, 32'(VEC_STRIDE), 32'(win_idx));

  int_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_prio (
    .req (pending & mask),
    .any (any),
    .idx (win_idx)
  );

  // State register plus registered status outputs derived from next state.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      irq        <= 1'b0;
      in_service <= 1'b0;
    end else begin
      state      <= state_nxt;
      irq        <= (state_nxt == REQ);
      in_service <= (state_nxt == SERVICE);
    end
  end

  // Next state: ack only counts in REQ, eret only in SERVICE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any)     state_nxt = REQ;
      REQ:     if (int_ack) state_nxt = SERVICE;
      SERVICE: if (eret)    state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Control strobes: latch the winner in IDLE, clear its pending bit on ack.
  always_comb begin
    load   = (state == IDLE) && any;
    ack_ok = (state == REQ) && int_ack;
    clr    = '0;
    for (int i = 0; i < NUM_SRC; i++)
      clr[i] = ack_ok && (svc_id == IDX_W'(i));
  end

  // Edge capture, pending latches (set beats clear) and mask register.
  // src_q resets high so a line already high at release raises no event.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      src_q   <= '1;
      pending <= '0;
      mask    <= '1;
    end else begin
      src_q   <= src;
      pending <= (pending & ~clr) | edge_det;
      if (mask_we) mask <= mask_wd;
    end
  end

  // Request identity and vector, frozen once the request is committed.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      svc_id   <= '0;
      int_addr <= '0;
    end else if (load) begin
      svc_id   <= win_idx;
      int_addr <= ADDR_W'(win_addr);
    end
  end

endmodule

// File: tb/tb_vec_int_ctrl.sv
// Directed bench for vec_int_ctrl with NUM_SRC=4 and default vectors.
module tb_vec_int_ctrl;

  logic        Clk = 1'b0;
  logic        reset;
  logic [3:0]  src;
  logic        mask_we;
  logic [3:0]  mask_wd;
  logic        int_ack;
  logic        eret;
  logic        irq;
  logic [31:0] int_addr;
  logic        in_service;
  logic [1:0]  svc_id;
  logic [3:0]  pending;
  logic [3:0]  mask;

  int tests = 0;
  int fails = 0;

  vec_int_ctrl #(
    .NUM_SRC    (4),
    .ADDR_W     (32),
    .VEC_BASE   (32'h0000_0100),
    .VEC_STRIDE (8)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .src        (src),
    .mask_we    (mask_we),
    .mask_wd    (mask_wd),
    .int_ack    (int_ack),
    .eret       (eret),
    .irq        (irq),
    .int_addr   (int_addr),
    .in_service (in_service),
    .svc_id     (svc_id),
    .pending    (pending),
    .mask       (mask)
  );

  always #5 Clk = ~Clk;

  // One rising edge, then settle so outputs are read away from the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; src = '0; mask_we = 1'b0; mask_wd = '0;
    int_ack = 1'b0; eret = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rst_irq: got %0b want 0", irq); end
    tests++; if (in_service !== 1'b0) begin fails++; $display("FAIL rst_insvc: got %0b want 0", in_service); end
    tests++; if (svc_id !== 2'd0) begin fails++; $display("FAIL rst_svc: got %0d want 0", svc_id); end
    tests++; if (int_addr !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h want 0", int_addr); end
    tests++; if (pending !== 4'b0000) begin fails++; $display("FAIL rst_pend: got %b want 0000", pending); end
    tests++; if (mask !== 4'b1111) begin fails++; $display("FAIL rst_mask: got %b want 1111", mask); end
  endtask

  task automatic test_basic();
    src = 4'b0100; tick();
    tests++; if (pending !== 4'b0100) begin fails++; $display("FAIL b_pend_set: got %b want 0100", pending); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL b_irq_early: got %0b want 0", irq); end
    src = 4'b0000; tick();
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL b_irq: got %0b want 1", irq); end
    tests++; if (svc_id !== 2'd2) begin fails++; $display("FAIL b_svc: got %0d want 2", svc_id); end
    tests++; if (int_addr !== 32'h110) begin fails++; $display("FAIL b_addr: got %h want 110", int_addr); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL b_ack_irq: got %0b want 0", irq); end
    tests++; if (in_service !== 1'b1) begin fails++; $display("FAIL b_ack_insvc: got %0b want 1", in_service); end
    tests++; if (pending !== 4'b0000) begin fails++; $display("FAIL b_ack_pend: got %b want 0000", pending); end
    eret = 1'b1; tick(); eret = 1'b0;
    tests++; if (in_service !== 1'b0) begin fails++; $display("FAIL b_eret_insvc: got %0b want 0", in_service); end
    tick(); tick();
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL b_idle_irq: got %0b want 0", irq); end
  endtask

  task automatic test_priority();
    src = 4'b1010; tick(); src = 4'b0000; tick();
    tests++; if (irq !== 1'b1 || svc_id !== 2'd1) begin fails++; $display("FAIL p_first: got irq=%0b svc=%0d want irq=1 svc=1", irq, svc_id); end
    tests++; if (int_addr !== 32'h108) begin fails++; $display("FAIL p_first_addr: got %h want 108", int_addr); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    tests++; if (pending !== 4'b1000) begin fails++; $display("FAIL p_pend: got %b want 1000", pending); end
    eret = 1'b1; tick(); eret = 1'b0;
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL p_gap_irq: got %0b want 0", irq); end
    tick();
    tests++; if (irq !== 1'b1 || svc_id !== 2'd3) begin fails++; $display("FAIL p_second: got irq=%0b svc=%0d want irq=1 svc=3", irq, svc_id); end
    tests++; if (int_addr !== 32'h118) begin fails++; $display("FAIL p_second_addr: got %h want 118", int_addr); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    eret = 1'b1; tick(); eret = 1'b0;
    tick();
    tests++; if (irq !== 1'b0 || pending !== 4'b0000) begin fails++; $display("FAIL p_drain: got irq=%0b pend=%b want irq=0 pend=0000", irq, pending); end
  endtask

  task automatic test_mask();
    mask_we = 1'b1; mask_wd = 4'b1110; tick(); mask_we = 1'b0;
    tests++; if (mask !== 4'b1110) begin fails++; $display("FAIL m_mask: got %b want 1110", mask); end
    src = 4'b0001; tick(); src = 4'b0000; tick(); tick();
    tests++; if (pending !== 4'b0001) begin fails++; $display("FAIL m_pend: got %b want 0001", pending); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL m_irq_masked: got %0b want 0", irq); end
    mask_we = 1'b1; mask_wd = 4'b1111; tick(); mask_we = 1'b0;
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL m_irq_wr: got %0b want 0", irq); end
    tick();
    tests++; if (irq !== 1'b1 || svc_id !== 2'd0) begin fails++; $display("FAIL m_unmask: got irq=%0b svc=%0d want irq=1 svc=0", irq, svc_id); end
    tests++; if (int_addr !== 32'h100) begin fails++; $display("FAIL m_addr: got %h want 100", int_addr); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  task automatic test_set_wins();
    src = 4'b0010; tick(); src = 4'b0000; tick();
    tests++; if (irq !== 1'b1 || svc_id !== 2'd1) begin fails++; $display("FAIL s_req: got irq=%0b svc=%0d want irq=1 svc=1", irq, svc_id); end
    src = 4'b0010; int_ack = 1'b1; tick(); src = 4'b0000; int_ack = 1'b0;
    tests++; if (pending !== 4'b0010) begin fails++; $display("FAIL s_pend: got %b want 0010", pending); end
    tests++; if (in_service !== 1'b1 || irq !== 1'b0) begin fails++; $display("FAIL s_svc: got insvc=%0b irq=%0b want insvc=1 irq=0", in_service, irq); end
    eret = 1'b1; tick(); eret = 1'b0;
    tick();
    tests++; if (irq !== 1'b1 || svc_id !== 2'd1) begin fails++; $display("FAIL s_rereq: got irq=%0b svc=%0d want irq=1 svc=1", irq, svc_id); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  task automatic test_illegal();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    tests++; if (irq !== 1'b0 || in_service !== 1'b0) begin fails++; $display("FAIL i_ack_idle: got irq=%0b insvc=%0b want 0 0", irq, in_service); end
    tests++; if (svc_id !== 2'd1) begin fails++; $display("FAIL i_ack_svc: got %0d want 1", svc_id); end
    src = 4'b0100; tick(); src = 4'b0000; tick();
    eret = 1'b1; tick(); eret = 1'b0;
    tests++; if (irq !== 1'b1 || in_service !== 1'b0) begin fails++; $display("FAIL i_eret_req: got irq=%0b insvc=%0b want 1 0", irq, in_service); end
    tests++; if (svc_id !== 2'd2 || int_addr !== 32'h110) begin fails++; $display("FAIL i_eret_hold: got svc=%0d addr=%h want 2 110", svc_id, int_addr); end
    int_ack = 1'b1; eret = 1'b1; tick(); int_ack = 1'b0; eret = 1'b0;
    tests++; if (in_service !== 1'b1 || irq !== 1'b0) begin fails++; $display("FAIL i_both_req: got insvc=%0b irq=%0b want 1 0", in_service, irq); end
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  task automatic test_reset_mid();
    mask_we = 1'b1; mask_wd = 4'b1100; tick(); mask_we = 1'b0;
    src = 4'b1000; tick(); src = 4'b0000; tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    src = 4'b0100; tick();
    tests++; if (in_service !== 1'b1 || pending !== 4'b0100) begin fails++; $display("FAIL r_setup: got insvc=%0b pend=%b want 1 0100", in_service, pending); end
    #2 reset = 1'b1;
    #1;
    tests++; if (irq !== 1'b0 || in_service !== 1'b0) begin fails++; $display("FAIL r_async_st: got irq=%0b insvc=%0b want 0 0", irq, in_service); end
    tests++; if (svc_id !== 2'd0 || int_addr !== 32'h0) begin fails++; $display("FAIL r_async_id: got svc=%0d addr=%h want 0 0", svc_id, int_addr); end
    tests++; if (pending !== 4'b0000 || mask !== 4'b1111) begin fails++; $display("FAIL r_async_pm: got pend=%b mask=%b want 0000 1111", pending, mask); end
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    tests++; if (irq !== 1'b0 || pending !== 4'b0000) begin fails++; $display("FAIL r_held_src: got irq=%0b pend=%b want 0 0000", irq, pending); end
    src = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_set_wins();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
